// File: rtl/trigger_counter_seq.sv
// Event-counting trigger generator for the ADS1672 capture path: discards settle
// events after start, then counts events per period and pulses ready at each period end.
module trigger_counter_seq #(
  parameter int CNT_WIDTH = 16,
  parameter int DLY_WIDTH = 8,
  parameter int PER_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic                 i_mode_cont,
  input  logic [DLY_WIDTH-1:0] i_delay_cfg,
  input  logic [CNT_WIDTH-1:0] i_count_cfg,
  input  logic                 i_event,
  output logic                 o_busy,
  output logic                 o_ready,
  output logic                 o_done,
  output logic                 o_cfg_err,
  output logic [CNT_WIDTH-1:0] o_count_out,
  output logic [PER_WIDTH-1:0] o_period_num
);

  typedef enum logic [1:0] {IDLE, SETTLE, COUNT, DONE} state_t;

  state_t               r_state, w_state_next;
  logic                 r_mode, w_mode;
  logic [DLY_WIDTH-1:0] r_delay, w_delay;
  logic [CNT_WIDTH-1:0] r_cfg, w_cfg;
  logic [DLY_WIDTH-1:0] r_settle, w_settle;
  logic [CNT_WIDTH-1:0] r_cnt, w_cnt;
  logic [PER_WIDTH-1:0] r_per, w_per;
  logic                 r_busy, w_busy;
  logic                 r_ready, w_ready;
  logic                 r_done, w_done;
  logic                 r_cfg_err, w_cfg_err;
  logic [CNT_WIDTH-1:0] w_cnt_base;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic [DLY_WIDTH-1:0] w_settle_inc;

  // In continuous mode count_out shows the terminal value for one cycle, then
  // restarts from zero; the next event always counts as 1.
  assign w_cnt_base   = (r_state == COUNT && r_cnt == r_cfg) ? '0 : r_cnt;
  assign w_cnt_inc    = w_cnt_base + CNT_WIDTH'(1);
  assign w_settle_inc = r_settle + DLY_WIDTH'(1);

  always_comb begin
    w_state_next = r_state;
    w_mode       = r_mode;
    w_delay      = r_delay;
    w_cfg        = r_cfg;
    w_settle     = r_settle;
    w_cnt        = r_cnt;
    w_per        = r_per;
    w_ready      = 1'b0;
    w_cfg_err    = 1'b0;
    if (i_abort) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (i_start) begin
            if (i_count_cfg == '0) begin
              w_cfg_err = 1'b1;
            end else begin
              w_mode       = i_mode_cont;
              w_delay      = i_delay_cfg;
              w_cfg        = i_count_cfg;
              w_settle     = '0;
              w_cnt        = '0;
              w_per        = '0;
              w_state_next = (i_delay_cfg != '0) ? SETTLE : COUNT;
            end
          end
        end
        SETTLE: begin
          if (i_event) begin
            w_settle = w_settle_inc;
            if (w_settle_inc == r_delay) w_state_next = COUNT;
          end
        end
        COUNT: begin
          w_cnt = w_cnt_base;
          if (i_event) begin
            w_cnt = w_cnt_inc;
            if (w_cnt_inc == r_cfg) begin
              w_ready = 1'b1;
              w_per   = r_per + PER_WIDTH'(1);
              if (!r_mode) w_state_next = DONE;
            end
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
    w_busy = (w_state_next == SETTLE) || (w_state_next == COUNT);
    w_done = (w_state_next == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mode    <= 1'b0;
      r_delay   <= '0;
      r_cfg     <= '0;
      r_settle  <= '0;
      r_cnt     <= '0;
      r_per     <= '0;
      r_busy    <= 1'b0;
      r_ready   <= 1'b0;
      r_done    <= 1'b0;
      r_cfg_err <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_mode    <= w_mode;
      r_delay   <= w_delay;
      r_cfg     <= w_cfg;
      r_settle  <= w_settle;
      r_cnt     <= w_cnt;
      r_per     <= w_per;
      r_busy    <= w_busy;
      r_ready   <= w_ready;
      r_done    <= w_done;
      r_cfg_err <= w_cfg_err;
    end
  end

  assign o_busy       = r_busy;
  assign o_ready      = r_ready;
  assign o_done       = r_done;
  assign o_cfg_err    = r_cfg_err;
  assign o_count_out  = r_cnt;
  assign o_period_num = r_per;

endmodule

// File: tb/tb_trigger_counter_seq.sv
// Self-checking bench for trigger_counter_seq: directed scenarios followed by random
// traffic, all compared each cycle against a behavioural model of the trigger rules.
module tb_trigger_counter_seq;

  localparam int CW = 8;
  localparam int DW = 4;
  localparam int PW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          modeCont = 1'b0;
  logic [DW-1:0] delayCfg = '0;
  logic [CW-1:0] countCfg = '0;
  logic          ev = 1'b0;
  logic          busy, ready, done, cfgErr;
  logic [CW-1:0] countOut;
  logic [PW-1:0] periodNum;

  int nCompared = 0;
  int nMismatched = 0;
  int cycle = 0;

  // Reference model: whether a run is active or finished, events still to
  // discard, the count shown for this period and completed periods.
  bit mActive, mFinished, mCont, mReady, mCfgErr;
  int mDiscard, mShown, mTarget, mPeriods;

  trigger_counter_seq #(.CNT_WIDTH(CW), .DLY_WIDTH(DW), .PER_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .i_start(start), .i_abort(abort),
    .i_mode_cont(modeCont), .i_delay_cfg(delayCfg), .i_count_cfg(countCfg),
    .i_event(ev), .o_busy(busy), .o_ready(ready), .o_done(done),
    .o_cfg_err(cfgErr), .o_count_out(countOut), .o_period_num(periodNum)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input int observed, input int expected);
    nCompared++;
    if (observed !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycle, observed, expected);
    end
  endtask

  task automatic modelStep();
    mReady  = 0;
    mCfgErr = 0;
    if (rst) begin
      mActive = 0; mFinished = 0; mCont = 0; mDiscard = 0;
      mShown = 0; mTarget = 0; mPeriods = 0;
    end else if (abort) begin
      mActive = 0;
      mFinished = 0;
    end else if (!mActive) begin
      if (start) begin
        if (countCfg == 0) mCfgErr = 1;
        else begin
          mActive = 1; mFinished = 0; mCont = modeCont;
          mDiscard = delayCfg; mTarget = countCfg; mShown = 0; mPeriods = 0;
        end
      end
    end else if (mDiscard > 0) begin
      if (ev) mDiscard--;
    end else begin
      if (mShown == mTarget) mShown = 0;
      if (ev) begin
        mShown++;
        if (mShown == mTarget) begin
          mReady = 1;
          mPeriods = (mPeriods + 1) % (1 << PW);
          if (!mCont) begin
            mActive = 0;
            mFinished = 1;
          end
        end
      end
    end
  endtask

  task automatic checkOutput();
    checkValue("busy", busy, mActive);
    checkValue("ready", ready, mReady);
    checkValue("done", done, mFinished);
    checkValue("cfgErr", cfgErr, mCfgErr);
    checkValue("countOut", countOut, mShown);
    checkValue("periodNum", periodNum, mPeriods);
  endtask

  task automatic applyStimulus(input bit r, input bit s, input bit a, input bit m,
                               input int d, input int c, input bit e);
    rst = r; start = s; abort = a; modeCont = m;
    delayCfg = DW'(d); countCfg = CW'(c); ev = e;
    @(posedge clk);
    modelStep();
    #1;
    cycle++;
    checkOutput();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic events(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      idle(gap);
    end
  endtask

  initial begin
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 1, 3, 5, 1);
    // single-shot without settle, spaced events
    applyStimulus(0, 1, 0, 0, 0, 4, 1);
    events(4, 2);
    idle(2);
    // settle discard with back-to-back events
    applyStimulus(0, 1, 0, 0, 3, 2, 0);
    events(5, 0);
    idle(2);
    // config error while done, then from idle
    applyStimulus(0, 1, 0, 1, 2, 0, 0);
    idle(1);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    idle(1);
    // continuous back-to-back across period boundaries
    applyStimulus(0, 1, 0, 1, 0, 3, 0);
    events(9, 0);
    applyStimulus(0, 1, 0, 0, 0, 7, 1);
    idle(2);
    // abort coinciding with the terminal event
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 2, 0);
    events(1, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 1);
    idle(2);
    applyStimulus(0, 1, 0, 0, 0, 2, 0);
    idle(1);
    // reset mid-count
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 1, 0, 3, 0);
    events(1, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    idle(1);
    // period wrap with count of one
    applyStimulus(0, 1, 0, 1, 0, 1, 0);
    events(5, 0);
    idle(2);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);

    for (int i = 0; i < 4000; i++) begin
      int cSel;
      cSel = $urandom_range(0, 6);
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 39) == 0,
                    $urandom_range(0, 1) == 1,
                    ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 2),
                    (cSel == 6) ? $urandom_range(7, 255) : cSel,
                    $urandom_range(0, 1) == 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/trigger_counter_seq.md
Name: trigger_counter_seq

Overview:
Parametrised event-counting trigger generator for the ADS1672 EVM capture path. After a start command it discards a programmable number of ADC data-ready events so the digital filter can settle. It then counts a programmable number of events and raises a ready pulse. It supports single-shot and continuous (periodic re-arm) modes, abort, and config error flagging. It sits between the ADC data-ready strobe and the capture/DMA control logic.

Parameters:
CNT_WIDTH, 16, width of count_cfg, count_out and the internal event counter
DLY_WIDTH, 8, width of delay_cfg and the internal settle-discard counter
PER_WIDTH, 16, width of period_num (continuous-mode period index)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  1-cycle request to arm; accepted only in IDLE or DONE
abort  in  1  1-cycle request to return to IDLE
mode_cont  in  1  0 = single-shot, 1 = continuous; sampled on accepted start
delay_cfg  in  DLY_WIDTH  events to discard before counting; sampled on accepted start
count_cfg  in  CNT_WIDTH  events per period; sampled on accepted start
event  in  1  ADC data-ready strobe, 1-cycle, already synchronous to clk
busy  out  1  high in SETTLE or COUNT
ready  out  1  1-cycle pulse at end of each counted period
done  out  1  level; high in DONE (single-shot complete)
cfg_err  out  1  1-cycle pulse when start is rejected for count_cfg == 0
count_out  out  CNT_WIDTH  events counted in current period
period_num  out  PER_WIDTH  completed periods since last accepted start; wraps

Behaviour:
- The design uses rst, synchronous, active-high, on clock clk. Reset has priority over everything.
- Reset values: state IDLE; busy=0, ready=0, done=0, cfg_err=0, count_out=0, period_num=0; shadow config regs = 0.
- All outputs are registered.
- States are IDLE, SETTLE, COUNT and DONE.
- Priority each cycle: rst > abort > start > event.
- IDLE/DONE with start=1:
  - If count_cfg==0: cfg_err pulses the next cycle and the state is unchanged (done stays as it was).
  - Otherwise the block latches mode_cont, delay_cfg and count_cfg, clears count_out, period_num and the settle counter, and clears done.
  - Next state is SETTLE if delay_cfg!=0, else COUNT.
  - An event in the same cycle as the accepted start is not counted.
- start while in SETTLE or COUNT is ignored, with no error.
- SETTLE: each event increments the settle counter. The event that makes it equal the latched delay moves the state to COUNT; that event is discarded, not counted.
- COUNT: each event increments count_out. The event that makes count_out equal the latched count_cfg is the terminal event.
  - ready=1 in the cycle after the terminal event (latency 1 clk from event); period_num increments in that same cycle.
  - Single-shot: next state is DONE. count_out holds the terminal value and done=1 until the next accepted start or abort.
  - Continuous: count_out returns to 0 and the state stays in COUNT.
  - The next event after the terminal event counts as 1. Back-to-back events on consecutive cycles must be counted with none lost, including across the period boundary.
- count_cfg==1 in continuous mode gives a ready pulse after every event.
- Wrap: period_num wraps from 2^PER_WIDTH-1 to 0 and has no sticky overflow. count_out cannot exceed count_cfg.
- abort (any state): next state is IDLE.
  - busy=0 and done=0.
  - count_out and period_num hold their last values until the next accepted start.
  - No ready pulse is produced, even if a terminal event coincides with the abort.
- rst asserted mid-SETTLE or mid-COUNT gives the full reset values in the next cycle, with no ready pulse.
- Config inputs are don't-care except in the cycle of an accepted start.

Test Plan:
- Single-shot, no settle: rst, start with delay_cfg=0, count_cfg=4, mode_cont=0, then 4 events 3 clk apart -> ready pulses once, 1 clk after the 4th event; done=1; count_out=4; period_num=1; busy=0.
- Settle discard: delay_cfg=3, count_cfg=2, single-shot, 5 back-to-back events -> first 3 are not counted; ready 1 clk after the 5th event; count_out=2.
- Continuous back-to-back: count_cfg=3, mode_cont=1, 9 events on consecutive cycles -> ready pulses 1 clk after events 3, 6 and 9; period_num=3; count_out sequence 1,2,3,1,2,3,... with no event lost.
- Config error: start with count_cfg=0 from IDLE -> cfg_err for 1 cycle; state stays IDLE; busy=0. Repeat from DONE -> done stays 1.
- Abort vs terminal event: count_cfg=2, abort in the same cycle as the 2nd event -> no ready pulse; IDLE; busy=0; count_out=1 held. A subsequent start clears count_out to 0.
- Reset mid-operation and wrap: rst during COUNT -> all outputs 0 next cycle. With PER_WIDTH=2 and count_cfg=1 continuous, 5 events -> period_num reads 1,2,3,0,1.
